// File: rtl/mips_run_pkg.sv
// rtl/mips_run_pkg.sv - shared state encodings and helpers for the mips run controller
//
// Purpose: run-controller FSM state encoding and a constant clog2 helper.
// Ports:   none (package).
package mips_run_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_RESET_HOLD = 2'b00,
    ST_RUN        = 2'b01,
    ST_HALTED     = 2'b10,
    ST_TIMEOUT    = 2'b11
  } run_state_t;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mips_rst_sync.sv
// rtl/mips_rst_sync.sv - 2-flop reset synchroniser, async assert / sync deassert
//
// Purpose: removes metastability from the release edge of the board reset while
//          still letting assertion take effect immediately.
// Ports:   clk      in  system clock
//          rst_in_n in  raw asynchronous active-low reset
//          rst_n    out synchronised active-low reset
module mips_rst_sync (
  input  logic clk,
  input  logic rst_in_n,
  output logic rst_n
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_n = sync_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run controller: core reset sequencing, enable gating, counters, watchdog
//
// Purpose: holds the core in reset for RST_CYCLES after release/restart, then gates
//          core_en from run_en, counts enabled cycles and retires, and stops on halt,
//          no-retire watchdog or cycle budget. Optional retired-PC trace buffer is
//          built only when the macro MIPS_RUN_TRACE_EN is defined.
// Ports:   clk, rst (async active-low), run_en, restart, wb_valid, wb_pc[31:0], halt_req,
//          trace_idx  -> inputs
//          core_rst_n, core_en, cycle_cnt, retire_cnt, done, timeout, state[1:0],
//          trace_pc[31:0] -> outputs
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int RST_CYCLES  = 16,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 256,
  parameter int MAX_CYCLES  = 2**20,
  parameter int TRACE_DEPTH = 8,
  localparam int IDX_W      = (clog2(TRACE_DEPTH) < 1) ? 1 : clog2(TRACE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             restart,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic             halt_req,
  output logic             core_rst_n,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       state,
  input  logic [IDX_W-1:0] trace_idx,
  output logic [31:0]      trace_pc
);

  localparam int HOLD_W = (clog2(RST_CYCLES) < 1) ? 1 : clog2(RST_CYCLES);
  localparam int WD_W   = (clog2(WDOG_CYCLES + 1) < 1) ? 1 : clog2(WDOG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);
  localparam logic [63:0]       BUDGET_LAST = 64'(MAX_CYCLES) - 64'd1;

  logic rst_n;

  mips_rst_sync u_rst_sync (
    .clk      (clk),
    .rst_in_n (rst),
    .rst_n    (rst_n)
  );

  run_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WD_W-1:0]   wdog;
  logic adv, retire, halt_hit, wdog_hit, budget_hit, hold_done, clear;

  always_comb begin
    state_d    = state_q;
    clear      = 1'b0;
    adv        = (state_q == ST_RUN) && core_en;
    retire     = adv && wb_valid;
    halt_hit   = retire && halt_req;
    // Expire on the enabled cycle that would take the watchdog to WDOG_CYCLES.
    wdog_hit   = (WDOG_CYCLES != 0) && adv && !wb_valid && (wdog == WD_LAST);
    budget_hit = (MAX_CYCLES != 0) && adv && (64'(cycle_cnt) == BUDGET_LAST);
    hold_done  = (hold_cnt == HOLD_LAST);
    case (state_q)
      ST_RESET_HOLD: if (hold_done) state_d = ST_RUN;
      ST_RUN: begin
        // Halt has priority over any expiry in the same cycle.
        if (halt_hit)                      state_d = ST_HALTED;
        else if (wdog_hit || budget_hit)   state_d = ST_TIMEOUT;
      end
      default: begin
        if (restart) begin
          state_d = ST_RESET_HOLD;
          clear   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET_HOLD;
      hold_cnt   <= '0;
      core_rst_n <= 1'b0;
      core_en    <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      wdog       <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        hold_cnt   <= '0;
        core_rst_n <= 1'b0;
        core_en    <= 1'b0;
        cycle_cnt  <= '0;
        retire_cnt <= '0;
        wdog       <= '0;
        done       <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        if ((state_q == ST_RESET_HOLD) && !hold_done) hold_cnt <= hold_cnt + 1'b1;
        // Released on the same edge the FSM enters RUN; stays high in terminal
        // states, where the core is frozen by core_en instead.
        core_rst_n <= (state_d != ST_RESET_HOLD);
        core_en    <= (state_q == ST_RUN) && (state_d == ST_RUN) && run_en;
        if (adv) begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (wb_valid)        wdog <= '0;
          else if (wdog != '1) wdog <= wdog + 1'b1;
        end
        if (retire && (retire_cnt != '1)) retire_cnt <= retire_cnt + 1'b1;
        if (halt_hit)                   done    <= 1'b1;
        else if (state_d == ST_TIMEOUT) timeout <= 1'b1;
      end
    end
  end

  assign state = state_q;

`ifdef MIPS_RUN_TRACE_EN
  logic [31:0]      trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
    end else if (retire) begin
      trace_mem[wr_ptr] <= wb_pc;
      wr_ptr            <= wr_ptr + 1'b1;
    end
  end

  // Index 0 is the newest entry; pointer arithmetic wraps at the power-of-2 depth.
  assign rd_ptr   = wr_ptr - 1'b1 - trace_idx;
  assign trace_pc = trace_mem[rd_ptr];
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, wb_pc};
  assign trace_pc     = 32'h0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - self-checking bench for mips_run_ctrl
module tb_mips_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, run_en, restart, wb_valid, halt_req;
  logic [31:0] wb_pc;
  logic [1:0]  trace_idx;

  logic        core_rst_n, core_en, done, timeout;
  logic [3:0]  cycle_cnt, retire_cnt;
  logic [1:0]  state;
  logic [31:0] trace_pc;

  logic        c2_core_rst_n, c2_core_en, c2_done, c2_timeout;
  logic [7:0]  c2_cycle_cnt, c2_retire_cnt;
  logic [1:0]  c2_state;
  logic [31:0] c2_trace_pc;

  always #5 clk = ~clk;

  mips_run_ctrl #(.RST_CYCLES(16), .CNT_W(4), .WDOG_CYCLES(8), .MAX_CYCLES(2**20), .TRACE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .restart(restart), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .halt_req(halt_req), .core_rst_n(core_rst_n), .core_en(core_en),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .done(done), .timeout(timeout),
    .state(state), .trace_idx(trace_idx), .trace_pc(trace_pc)
  );

  // Budget-only instance: watchdog disabled, 12-cycle budget.
  mips_run_ctrl #(.RST_CYCLES(16), .CNT_W(8), .WDOG_CYCLES(0), .MAX_CYCLES(12), .TRACE_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .run_en(run_en), .restart(restart), .wb_valid(wb_valid),
    .wb_pc(wb_pc), .halt_req(halt_req), .core_rst_n(c2_core_rst_n), .core_en(c2_core_en),
    .cycle_cnt(c2_cycle_cnt), .retire_cnt(c2_retire_cnt), .done(c2_done), .timeout(c2_timeout),
    .state(c2_state), .trace_idx(trace_idx), .trace_pc(c2_trace_pc)
  );

`ifdef MIPS_RUN_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  typedef struct {
    logic       run_en, wb_valid, halt_req, restart;
    logic [1:0] st;
    logic       en;
    int         cyc, ret;
    logic       dn, to;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic w, input logic h, input logic s,
                              input logic [1:0] st, input logic en, input int cyc, input int ret,
                              input logic dn, input logic to);
    vec_t v;
    v.run_en = r; v.wb_valid = w; v.halt_req = h; v.restart = s;
    v.st = st; v.en = en; v.cyc = cyc; v.ret = ret; v.dn = dn; v.to = to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    run_en = 1'b1; restart = 1'b0; wb_valid = 1'b0; halt_req = 1'b0;
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      run_en = vecs[i].run_en; wb_valid = vecs[i].wb_valid;
      halt_req = vecs[i].halt_req; restart = vecs[i].restart;
      tick();
      check($sformatf("vec%0d_state", i),   32'(state),      32'(vecs[i].st));
      check($sformatf("vec%0d_core_en", i), 32'(core_en),    32'(vecs[i].en));
      check($sformatf("vec%0d_cycle", i),   32'(cycle_cnt),  32'(vecs[i].cyc));
      check($sformatf("vec%0d_retire", i),  32'(retire_cnt), 32'(vecs[i].ret));
      check($sformatf("vec%0d_done", i),    32'(done),       32'(vecs[i].dn));
      check($sformatf("vec%0d_timeout", i), 32'(timeout),    32'(vecs[i].to));
    end
    idle_inputs();
  endtask

  // Counts clocks until core_rst_n rises (bounded), then steps once so core_en is up.
  task automatic hold_and_start(input string name, input int exp_clocks);
    int n;
    n = 0;
    while (core_rst_n !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({name, "_clocks"}, 32'(n), 32'(exp_clocks));
    check({name, "_state"}, 32'(state), 32'h1);
    tick();
    check({name, "_core_en"}, 32'(core_en), 32'h1);
    check({name, "_cycle0"}, 32'(cycle_cnt), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    // Segment A: 10 retires, halt retire, ignored retire in HALTED, restart.
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1, 1, 0, 0, 2'b01, 1, i + 1, i + 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 11, 11, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 2'b10, 0, 11, 11, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    // Segment B (13..27): watchdog with a 5-cycle pause; retire while paused is ignored.
    vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'b01, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'b01, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'b01, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2'b01, 0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'b01, 0, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, 3, 0, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, 4 + i, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b11, 0, 8, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 2'b11, 0, 8, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    // Segment C (28..36): halt on the cycle the watchdog would reach 8.
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 0, 0, 0, 2'b01, 1, i + 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 2'b10, 0, 8, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));

    rst = 1'b0; wb_pc = '0; trace_idx = '0;
    idle_inputs();
    tick(); tick(); tick();
    check("rst_state",      32'(state),      32'h0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'h0);
    check("rst_core_en",    32'(core_en),    32'h0);
    check("rst_cycle",      32'(cycle_cnt),  32'h0);
    check("rst_retire",     32'(retire_cnt), 32'h0);
    check("rst_done",       32'(done),       32'h0);
    check("rst_timeout",    32'(timeout),    32'h0);
    check("rst_trace",      trace_pc,        32'h0);

    // Two synchroniser clocks plus 16 hold clocks.
    rst = 1'b1;
    hold_and_start("release", 18);

    apply_range(0, 12);
    hold_and_start("restart_a", 16);
    apply_range(13, 27);
    hold_and_start("restart_b", 16);
    apply_range(28, 36);
    hold_and_start("restart_c", 16);

    // Saturation at 4 bits.
    for (int i = 0; i < 20; i++) begin
      wb_valid = 1'b1; wb_pc = 32'(4 * i);
      tick();
    end
    wb_valid = 1'b0;
    check("sat_retire", 32'(retire_cnt), 32'hF);
    check("sat_cycle",  32'(cycle_cnt),  32'hF);
    check("sat_state",  32'(state),      32'h1);
    wb_valid = 1'b1; halt_req = 1'b1;
    tick();
    idle_inputs();
    check("sat_halt_state",  32'(state),      32'h2);
    check("sat_halt_retire", 32'(retire_cnt), 32'hF);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_retire",     32'(retire_cnt), 32'h0);
    check("restart_cycle",      32'(cycle_cnt),  32'h0);
    check("restart_core_rst_n", 32'(core_rst_n), 32'h0);
    check("restart_done",       32'(done),       32'h0);
    hold_and_start("restart_d", 16);

    // Trace: two retires, unwritten slot, then wrap with four more.
    wb_valid = 1'b1;
    wb_pc = 32'h00; tick();
    wb_pc = 32'h04; tick();
    wb_valid = 1'b0;
    trace_idx = 2'd0; #1 check("trace_early0", trace_pc, TRACE_ON ? 32'h04 : 32'h0);
    trace_idx = 2'd1; #1 check("trace_early1", trace_pc, TRACE_ON ? 32'h00 : 32'h0);
    trace_idx = 2'd2; #1 check("trace_unwritten", trace_pc, 32'h0);
    wb_valid = 1'b1;
    for (int i = 2; i < 6; i++) begin
      wb_pc = 32'(4 * i);
      tick();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      trace_idx = 2'(i);
      #1 check($sformatf("trace_idx%0d", i), trace_pc, TRACE_ON ? (32'h14 - 32'(4 * i)) : 32'h0);
    end
    trace_idx = 2'd0;

    // Asynchronous reset mid-RUN, checked between clock edges.
    #2 rst = 1'b0;
    #1;
    check("midrst_state",      32'(state),      32'h0);
    check("midrst_core_rst_n", 32'(core_rst_n), 32'h0);
    check("midrst_retire",     32'(retire_cnt), 32'h0);
    check("midrst_cycle",      32'(cycle_cnt),  32'h0);
    check("midrst_trace",      trace_pc,        32'h0);
    check("midrst_c2_trace",   c2_trace_pc,     32'h0);
    tick(); tick();
    rst = 1'b1;
    hold_and_start("rerelease", 18);

    // Budget vs halt in the same cycle: halt wins.
    wb_valid = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check("c2_pre_cycle", 32'(c2_cycle_cnt), 32'd11);
    check("c2_pre_state", 32'(c2_state),     32'h1);
    halt_req = 1'b1;
    tick();
    idle_inputs();
    check("c2_conf_state",   32'(c2_state),     32'h2);
    check("c2_conf_done",    32'(c2_done),      32'h1);
    check("c2_conf_timeout", 32'(c2_timeout),   32'h0);
    check("c2_conf_cycle",   32'(c2_cycle_cnt), 32'd12);
    check("conf_state",      32'(state),        32'h2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    hold_and_start("restart_e", 16);

    // Budget expiry alone.
    wb_valid = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    idle_inputs();
    check("c2_bud_state",      32'(c2_state),      32'h3);
    check("c2_bud_timeout",    32'(c2_timeout),    32'h1);
    check("c2_bud_cycle",      32'(c2_cycle_cnt),  32'd12);
    check("c2_bud_retire",     32'(c2_retire_cnt), 32'd12);
    check("c2_bud_core_en",    32'(c2_core_en),    32'h0);
    check("c2_bud_core_rst_n", 32'(c2_core_rst_n), 32'h1);
    check("bud_dut1_state",    32'(state),         32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
